// File: rtl/unidad_acceso_memoria.sv
// Load/store unit: turns byte/half/word accesses into word accesses on memoria_datos.
// Optional statistics counters are enabled with the UAM_CONTADORES_EN macro.
module unidad_acceso_memoria #(
    parameter int LAT_LECT = 1
`ifdef UAM_CONTADORES_EN
    ,
    parameter int ANCHO_CONT = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LeerMem,
    input  logic        EscrMem,
    input  logic [1:0]  Tam,
    input  logic        ConSigno,
    input  logic [31:0] Direc,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        stall,
    output logic        listo,
    output logic        error_al,
    output logic [31:0] Direc_m,
    output logic [31:0] Datain_m,
    output logic        LeerMem_m,
    output logic        EscrMem_m,
    input  logic [31:0] Dataout_m,
    output logic [1:0]  estado
`ifdef UAM_CONTADORES_EN
    ,
    output logic [ANCHO_CONT-1:0] n_cargas,
    output logic [ANCHO_CONT-1:0] n_almac,
    output logic [ANCHO_CONT-1:0] n_errores
`endif
);

    // Handshake: the processor holds LeerMem/EscrMem and operands stable while stall=1;
    // listo pulses exactly once per accepted request, and a new request may follow next cycle.
    typedef enum logic [1:0] {S_REPOSO, S_CARGA, S_RMW_LEE, S_RMW_ESC} estado_t;

    localparam logic [1:0] CONT_INI = 2'(LAT_LECT - 1);

    estado_t     estado_q, estado_d;
    logic [1:0]  cont_q, cont_d;
    logic [31:0] dir_q, dato_q, fusion_q, dataout_q;
    logic [1:0]  tam_q;
    logic        signo_q;
    logic        captura, guarda;
    logic        error_req;
    logic [31:0] carga_ext, fusion_d;

    function automatic logic [31:0] extender(input logic [31:0] w, input logic [1:0] t,
                                             input logic [1:0] k, input logic s);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{k, 3'b000} +: 8];
        h = k[1] ? w[31:16] : w[15:0];
        case (t)
            2'b00:   r = {{24{s & b[7]}}, b};
            2'b01:   r = {{16{s & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] fusionar(input logic [31:0] w, input logic [1:0] t,
                                             input logic [1:0] k, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (t)
            2'b00: r[{k, 3'b000} +: 8] = d[7:0];
            2'b01: begin
                if (k[1]) r[31:16] = d[15:0];
                else      r[15:0]  = d[15:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    assign error_req = (LeerMem | EscrMem) &
                       ((LeerMem & EscrMem) | (Tam == 2'b11) |
                        ((Tam == 2'b01) & Direc[0]) |
                        ((Tam == 2'b10) & (Direc[1:0] != 2'b00)));

    // Lane selection works on the operands latched at acceptance, not the live inputs.
    assign carga_ext = extender(Dataout_m, tam_q, dir_q[1:0], signo_q);
    assign fusion_d  = fusionar(Dataout_m, tam_q, dir_q[1:0], dato_q);
    assign estado    = estado_q;

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        stall     = 1'b0;
        listo     = 1'b0;
        error_al  = 1'b0;
        LeerMem_m = 1'b0;
        EscrMem_m = 1'b0;
        Direc_m   = '0;
        Datain_m  = '0;
        Dataout   = dataout_q;
        captura   = 1'b0;
        guarda    = 1'b0;
        case (estado_q)
            S_REPOSO: begin
                if (error_req) begin
                    listo    = 1'b1;
                    error_al = 1'b1;
                    Dataout  = '0;
                end else if (EscrMem && Tam == 2'b10) begin
                    EscrMem_m = 1'b1;
                    Direc_m   = {Direc[31:2], 2'b00};
                    Datain_m  = Datain;
                    listo     = 1'b1;
                end else if (LeerMem || EscrMem) begin
                    LeerMem_m = 1'b1;
                    Direc_m   = {Direc[31:2], 2'b00};
                    stall     = 1'b1;
                    captura   = 1'b1;
                    cont_d    = CONT_INI;
                    estado_d  = LeerMem ? S_CARGA : S_RMW_LEE;
                end
            end
            S_CARGA: begin
                LeerMem_m = 1'b1;
                Direc_m   = {dir_q[31:2], 2'b00};
                if (cont_q != 2'd0) begin
                    cont_d = cont_q - 2'd1;
                    stall  = 1'b1;
                end else begin
                    Dataout  = carga_ext;
                    listo    = 1'b1;
                    estado_d = S_REPOSO;
                end
            end
            S_RMW_LEE: begin
                LeerMem_m = 1'b1;
                Direc_m   = {dir_q[31:2], 2'b00};
                stall     = 1'b1;
                if (cont_q != 2'd0) begin
                    cont_d = cont_q - 2'd1;
                end else begin
                    guarda   = 1'b1;
                    estado_d = S_RMW_ESC;
                end
            end
            S_RMW_ESC: begin
                EscrMem_m = 1'b1;
                Direc_m   = {dir_q[31:2], 2'b00};
                Datain_m  = fusion_q;
                listo     = 1'b1;
                estado_d  = S_REPOSO;
            end
            default: estado_d = S_REPOSO;
        endcase
        // Reset silences the memory side immediately, even mid-access.
        if (reset) begin
            stall     = 1'b0;
            listo     = 1'b0;
            error_al  = 1'b0;
            LeerMem_m = 1'b0;
            EscrMem_m = 1'b0;
            Direc_m   = '0;
            Datain_m  = '0;
            Dataout   = '0;
            captura   = 1'b0;
            guarda    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= S_REPOSO;
            cont_q    <= 2'd0;
            dir_q     <= '0;
            dato_q    <= '0;
            tam_q     <= 2'b00;
            signo_q   <= 1'b0;
            fusion_q  <= '0;
            dataout_q <= '0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            dataout_q <= Dataout;
            if (captura) begin
                dir_q   <= Direc;
                dato_q  <= Datain;
                tam_q   <= Tam;
                signo_q <= ConSigno;
            end
            if (guarda) fusion_q <= fusion_d;
        end
    end

`ifdef UAM_CONTADORES_EN
    localparam logic [ANCHO_CONT-1:0] CONT_MAX = '1;
    localparam logic [ANCHO_CONT-1:0] UNO      = {{(ANCHO_CONT-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            n_cargas  <= '0;
            n_almac   <= '0;
            n_errores <= '0;
        end else begin
            if (listo && !error_al && !EscrMem_m && n_cargas != CONT_MAX)
                n_cargas <= n_cargas + UNO;
            if (listo && EscrMem_m && n_almac != CONT_MAX)
                n_almac <= n_almac + UNO;
            if (error_al && n_errores != CONT_MAX)
                n_errores <= n_errores + UNO;
        end
    end
`endif

endmodule

// File: tb/tb_unidad_acceso_memoria.sv
// Bench for unidad_acceso_memoria: two instances (LAT_LECT=1 and 3), each with its own memory.
`timescale 1ns/1ps
module tb_unidad_acceso_memoria;

    typedef struct packed {
        logic        stall;
        logic        listo;
        logic        err;
        logic        rd;
        logic        wr;
        logic [31:0] dout;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;
    localparam logic [31:0] A = 32'hFFFF_FF10;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        leer [2], escr [2], signo [2];
    logic [1:0]  tam [2];
    logic [31:0] dir [2], din [2];
    logic [31:0] dout [2], dir_m [2], din_m [2], dm [2];
    logic        stall_o [2], listo_o [2], err_o [2], rd_m [2], wr_m [2];
    logic [1:0]  est [2];
    logic [31:0] cnt_c [2], cnt_a [2], cnt_e [2];

    int n_vec = 0;
    int n_fail = 0;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [31:0] ref_mem [2][16];
    logic [31:0] last_dout [2];
    int          m_cargas [2], m_almac [2], m_err [2];

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int L = (g == 0) ? 1 : 3;
        localparam int WC = (g == 0) ? 16 : 2;
        logic [31:0] mem [16];
        logic [31:0] pipe [L];
        logic [WC-1:0] nc, na, ne;

        always @(posedge clk) begin
            if (wr_m[g]) mem[dir_m[g][5:2]] <= din_m[g];
            pipe[0] <= rd_m[g] ? mem[dir_m[g][5:2]] : 32'hBADB_AD00;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign dm[g] = pipe[L-1];
`ifdef UAM_CONTADORES_EN
        assign cnt_c[g] = 32'(nc);
        assign cnt_a[g] = 32'(na);
        assign cnt_e[g] = 32'(ne);
`else
        assign nc = '0;
        assign na = '0;
        assign ne = '0;
        assign cnt_c[g] = 32'(nc);
        assign cnt_a[g] = 32'(na);
        assign cnt_e[g] = 32'(ne);
`endif

        unidad_acceso_memoria #(
            .LAT_LECT(L)
`ifdef UAM_CONTADORES_EN
            , .ANCHO_CONT(WC)
`endif
        ) dut (
            .clk(clk), .reset(rst[g]), .LeerMem(leer[g]), .EscrMem(escr[g]), .Tam(tam[g]),
            .ConSigno(signo[g]), .Direc(dir[g]), .Datain(din[g]), .Dataout(dout[g]),
            .stall(stall_o[g]), .listo(listo_o[g]), .error_al(err_o[g]), .Direc_m(dir_m[g]),
            .Datain_m(din_m[g]), .LeerMem_m(rd_m[g]), .EscrMem_m(wr_m[g]), .Dataout_m(dm[g]),
            .estado(est[g])
`ifdef UAM_CONTADORES_EN
            , .n_cargas(nc), .n_almac(na), .n_errores(ne)
`endif
        );
    end

    // reference model of the access rules
    function automatic logic m_is_err(input logic ld, input logic st, input logic [1:0] t,
                                      input logic [1:0] k);
        if (!ld && !st) return 1'b0;
        return (ld && st) || t == 2'b11 || (t == H && k[0]) || (t == W && k != 2'b00);
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] t,
                                          input logic [1:0] k, input logic s);
        logic [31:0] v;
        if (t == B) begin
            v = (w >> (8 * k)) & 32'hFF;
            if (s && v[7]) v = v | 32'hFFFF_FF00;
        end else if (t == H) begin
            v = (w >> (16 * k[1])) & 32'hFFFF;
            if (s && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] t,
                                            input logic [1:0] k, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        sh   = (t == B) ? 8 * k : 16 * k[1];
        mask = ((t == B) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    function automatic int m_sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // scoreboard
    task automatic check(input string nm, input int u, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s u%0d @%0t: got %h want %h", nm, u, $time, got, want);
        end
    endtask

    task automatic push(input int u, input exp_t e);
        if (u == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            e = '0;
            e.dout = last_dout[u];
            if (u == 0 && exp_q0.size() > 0)      e = exp_q0.pop_front();
            else if (u == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            check("stall", u, {31'b0, stall_o[u]}, {31'b0, e.stall});
            check("listo", u, {31'b0, listo_o[u]}, {31'b0, e.listo});
            check("error_al", u, {31'b0, err_o[u]}, {31'b0, e.err});
            check("LeerMem_m", u, {31'b0, rd_m[u]}, {31'b0, e.rd});
            check("EscrMem_m", u, {31'b0, wr_m[u]}, {31'b0, e.wr});
            check("Dataout", u, dout[u], e.dout);
            if (e.rd || e.wr) check("Direc_m", u, dir_m[u], e.addr);
            if (e.wr) check("Datain_m", u, din_m[u], e.wdata);
        end
    end

    // driver tasks
    task automatic txn(input int u, input logic ld, input logic st, input logic [1:0] t,
                       input logic s, input logic [31:0] a, input logic [31:0] d,
                       input logic chk, input logic [31:0] lit);
        exp_t        e;
        int          lat, n;
        logic [3:0]  idx;
        logic [31:0] v;
        lat = (u == 0) ? 1 : 3;
        idx = a[5:2];
        leer[u] = ld; escr[u] = st; tam[u] = t; signo[u] = s; dir[u] = a; din[u] = d;
        e = '0;
        e.dout = last_dout[u];
        e.addr = {a[31:2], 2'b00};
        n = 1;
        if (m_is_err(ld, st, t, a[1:0])) begin
            e.listo = 1'b1; e.err = 1'b1; e.dout = '0;
            push(u, e);
            last_dout[u] = '0;
            m_err[u]++;
        end else if (st && t == W) begin
            e.listo = 1'b1; e.wr = 1'b1; e.wdata = d;
            push(u, e);
            ref_mem[u][idx] = d;
            m_almac[u]++;
        end else if (ld) begin
            e.stall = 1'b1; e.rd = 1'b1;
            repeat (lat) push(u, e);
            v = m_ext(ref_mem[u][idx], t, a[1:0], s);
            e.stall = 1'b0; e.listo = 1'b1; e.dout = v;
            push(u, e);
            last_dout[u] = v;
            n = lat + 1;
            m_cargas[u]++;
            if (chk) check("lit_load", u, v, lit);
        end else if (st) begin
            e.stall = 1'b1; e.rd = 1'b1;
            repeat (lat + 1) push(u, e);
            v = m_merge(ref_mem[u][idx], t, a[1:0], d);
            ref_mem[u][idx] = v;
            e.stall = 1'b0; e.rd = 1'b0; e.wr = 1'b1; e.listo = 1'b1; e.wdata = v;
            push(u, e);
            n = lat + 2;
            m_almac[u]++;
            if (chk) check("lit_merge", u, v, lit);
        end else begin
            push(u, e);
        end
        @(posedge clk); #1;
        // operands change mid-access; the unit must keep using the accepted ones
        for (int i = 1; i < n; i++) begin
            dir[u] = ~a; din[u] = ~d; tam[u] = ~t; signo[u] = ~s;
            @(posedge clk); #1;
        end
    endtask

    task automatic rest(input int u);
        leer[u] = 1'b0; escr[u] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rst_mid(input int u, input logic [31:0] a);
        exp_t e;
        leer[u] = 1'b0; escr[u] = 1'b1; tam[u] = B; signo[u] = 1'b0; dir[u] = a; din[u] = 32'h55;
        e = '0;
        e.stall = 1'b1; e.rd = 1'b1; e.addr = {a[31:2], 2'b00}; e.dout = last_dout[u];
        push(u, e);
        @(posedge clk); #1;
        rst[u] = 1'b1; escr[u] = 1'b0;
        e = '0;
        push(u, e);
        last_dout[u] = '0;
        @(posedge clk); #1;
        rst[u] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic scen(input int u);
        txn(u, 0, 1, W, 0, A, 32'hDEAD_BEEF, 0, 0);
        txn(u, 1, 0, W, 0, A, 0, 1, 32'hDEAD_BEEF);
        rest(u);
        txn(u, 0, 1, W, 0, A, 32'h1122_3344, 0, 0);
        txn(u, 0, 1, B, 0, A + 32'd2, 32'h1234_56A5, 1, 32'h11A5_3344);
        txn(u, 1, 0, B, 1, A + 32'd2, 0, 1, 32'hFFFF_FFA5);
        txn(u, 1, 0, B, 0, A + 32'd2, 0, 1, 32'h0000_00A5);
        txn(u, 1, 0, W, 0, A, 0, 1, 32'h11A5_3344);
        txn(u, 0, 1, H, 0, A + 32'd2, 32'hCAFE_8001, 1, 32'h8001_3344);
        txn(u, 1, 0, H, 1, A + 32'd2, 0, 1, 32'hFFFF_8001);
        txn(u, 1, 0, H, 1, A, 0, 1, 32'h0000_3344);
        txn(u, 0, 1, B, 0, A + 32'd3, 32'h0000_007F, 1, 32'h7F01_3344);
        txn(u, 1, 0, B, 1, A + 32'd3, 0, 1, 32'h0000_007F);
        txn(u, 1, 0, B, 1, A, 0, 1, 32'h0000_0044);
        rest(u);
        txn(u, 1, 0, H, 0, A + 32'd1, 0, 0, 0);
        txn(u, 0, 1, W, 0, A + 32'd2, 32'h0BAD_F00D, 0, 0);
        txn(u, 1, 0, 2'b11, 0, A, 0, 0, 0);
        txn(u, 1, 1, W, 0, A, 0, 0, 0);
        txn(u, 0, 1, H, 0, A + 32'd1, 32'h0000_1234, 0, 0);
        rest(u);
        txn(u, 1, 0, W, 0, A, 0, 1, 32'h7F01_3344);
        rst_mid(u, A + 32'd1);
        txn(u, 1, 0, W, 0, A, 0, 1, 32'h7F01_3344);
        txn(u, 1, 0, B, 0, A + 32'd1, 0, 1, 32'h0000_0033);
        rest(u);
        rest(u);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; leer[u] = 1'b0; escr[u] = 1'b0; tam[u] = 2'b00; signo[u] = 1'b0;
            dir[u] = '0; din[u] = '0; last_dout[u] = '0;
            m_cargas[u] = 0; m_almac[u] = 0; m_err[u] = 0;
            for (int i = 0; i < 16; i++) ref_mem[u][i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        fork
            scen(0);
            scen(1);
        join
        repeat (2) @(posedge clk);
        #1;
        check("exp_q0_drained", 0, 32'(exp_q0.size()), 32'd0);
        check("exp_q1_drained", 1, 32'(exp_q1.size()), 32'd0);
`ifdef UAM_CONTADORES_EN
        for (int u = 0; u < 2; u++) begin
            check("n_cargas", u, cnt_c[u], 32'(m_sat(m_cargas[u], (u == 0) ? 16 : 2)));
            check("n_almac", u, cnt_a[u], 32'(m_sat(m_almac[u], (u == 0) ? 16 : 2)));
            check("n_errores", u, cnt_e[u], 32'(m_sat(m_err[u], (u == 0) ? 16 : 2)));
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
